// File: rtl/pool_window_feeder_pkg.sv
// Shared constants and FSM state encodings for the 2x2 pooling window feeder.
package pool_window_feeder_pkg;
  localparam int POOL_K    = 2;
  localparam int POOL_SIZE = POOL_K * POOL_K;

  typedef enum logic [1:0] {
    LOAD0 = 2'd0,
    LOAD1 = 2'd1,
    EMIT  = 2'd2
  } feeder_state_t;
endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel-stream input and window-beat output of the pooling feeder.
interface pool_window_feeder_if #(
  parameter int bits = 8
);
  logic [bits-1:0] pix_in;
  logic            pix_valid;
  logic            pix_ready;
  logic [bits-1:0] data_out;
  logic            start;
  logic            out_valid;
  logic            frame_done;

  modport master (
    input  pix_in, pix_valid,
    output pix_ready, data_out, start, out_valid, frame_done
  );

  modport slave (
    output pix_in, pix_valid,
    input  pix_ready, data_out, start, out_valid, frame_done
  );
endinterface

// File: rtl/pool_window_feeder_line_buf.sv
// One feature-map row of storage: single write port, combinational read port.
module pool_line_buf #(
  parameter int bits      = 8,
  parameter int depth     = 8,
  parameter int addr_bits = 3
) (
  input  logic                 clk_in,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [bits-1:0]      wr_dat,
  input  logic [addr_bits-1:0] rd_addr,
  output logic [bits-1:0]      rd_dat
);
  logic [bits-1:0] mem [depth];

  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/pool_window_feeder.sv
// Buffers two raster rows, then replays every 2x2 window as 4 back-to-back beats
// with start on beat 0; input is stalled (pix_ready low) for the whole replay.
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int bits     = 8,
  parameter int img_w    = 8,
  parameter int img_h    = 8,
  parameter int col_bits = 3,
  parameter int row_bits = 3
) (
  input  logic            clk_in,
  input  logic            rst,
  pool_window_feeder_if.master bus
);
  localparam int WINS = img_w / POOL_K;

  feeder_state_t       state;
  logic [col_bits-1:0] col;
  logic [col_bits-1:0] win;
  logic [col_bits-1:0] rd_col;
  logic [1:0]          beat;
  logic [row_bits-1:0] row;
  logic [bits-1:0]     rd0, rd1, beat_dat;
  logic                xfer, col_last, beat_last, win_last, row_last;

  assign xfer      = bus.pix_valid & bus.pix_ready;
  assign col_last  = (col == col_bits'(img_w - 1));
  assign beat_last = (beat == 2'(POOL_SIZE - 1));
  assign win_last  = (win == col_bits'(WINS - 1));
  assign row_last  = (row == row_bits'(img_h - POOL_K));

  // Beat order inside a window: top-left, top-right, bottom-left, bottom-right.
  assign rd_col   = col_bits'(win * POOL_K) + col_bits'(beat[0]);
  assign beat_dat = beat[1] ? rd1 : rd0;

  pool_line_buf #(.bits(bits), .depth(img_w), .addr_bits(col_bits)) line0 (
    .clk_in  (clk_in),
    .wr_en   (xfer && state == LOAD0),
    .wr_addr (col),
    .wr_dat  (bus.pix_in),
    .rd_addr (rd_col),
    .rd_dat  (rd0)
  );

  pool_line_buf #(.bits(bits), .depth(img_w), .addr_bits(col_bits)) line1 (
    .clk_in  (clk_in),
    .wr_en   (xfer && state == LOAD1),
    .wr_addr (col),
    .wr_dat  (bus.pix_in),
    .rd_addr (rd_col),
    .rd_dat  (rd1)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state          <= LOAD0;
      col            <= '0;
      row            <= '0;
      beat           <= '0;
      win            <= '0;
      bus.pix_ready  <= 1'b0;
      bus.data_out   <= '0;
      bus.start      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.start      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        LOAD0: begin
          bus.pix_ready <= 1'b1;
          if (xfer) begin
            if (col_last) begin
              col   <= '0;
              state <= LOAD1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        LOAD1: begin
          bus.pix_ready <= 1'b1;
          if (xfer) begin
            if (col_last) begin
              col           <= '0;
              beat          <= '0;
              win           <= '0;
              bus.pix_ready <= 1'b0;
              state         <= EMIT;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        EMIT: begin
          bus.pix_ready <= 1'b0;
          bus.data_out  <= beat_dat;
          bus.out_valid <= 1'b1;
          bus.start     <= (beat == 2'd0);
          beat          <= beat + 2'd1;
          if (beat_last) win <= win + 1'b1;
          // Last beat of the row pair: reopen the input on the same edge.
          if (beat_last && win_last) begin
            win            <= '0;
            bus.pix_ready  <= 1'b1;
            bus.frame_done <= row_last;
            row            <= row_last ? '0 : row + row_bits'(POOL_K);
            state          <= LOAD0;
          end
        end
        default: state <= LOAD0;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed + randomized bench for pool_window_feeder with a row-level reference model.
module tb_pool_window_feeder;
  localparam int BITS     = 8;
  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int COL_BITS = 2;
  localparam int ROW_BITS = 2;
  localparam int PAIRS    = IMG_H / 2;

  typedef logic [BITS-1:0] px_t;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  pool_window_feeder_if #(.bits(BITS)) bus ();

  pool_window_feeder #(
    .bits(BITS), .img_w(IMG_W), .img_h(IMG_H), .col_bits(COL_BITS), .row_bits(ROW_BITS)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  int  checks   = 0;
  int  errors   = 0;
  int  pair_idx = 0;
  px_t rows [2*IMG_W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // gap < 0 selects a random idle gap of 0..3 cycles before each pixel
  task automatic send_pair(input int first, input int gap);
    int g;
    bit done;
    for (int i = first; i < 2*IMG_W; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      bus.pix_valid = 1'b0;
      repeat (g) tick();
      bus.pix_in    = rows[i];
      bus.pix_valid = 1'b1;
      done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
        done = bus.pix_ready;
        tick();
      end
      chk("accept_timeout", 32'(done), 32'd1);
    end
    bus.pix_valid = 1'b0;
  endtask

  // Model: beat k of the replay is pixel (row b/2, column 2w + b%2), w = k/4, b = k%4.
  task automatic emit_check(input int abort_at);
    bit  frame_end;
    px_t exp, last, obs_max, mdl_max;
    int  w, b;
    frame_end = ((pair_idx % PAIRS) == PAIRS - 1);
    obs_max   = '0;
    last      = '0;
    chk("ready_low_after_last", 32'(bus.pix_ready), 32'd0);
    for (int k = 0; k < 2*IMG_W; k++) begin
      tick();
      w   = k / 4;
      b   = k % 4;
      exp = rows[(b / 2) * IMG_W + 2*w + (b % 2)];
      chk("beat_data", 32'(bus.data_out), 32'(exp));
      chk("beat_start", 32'(bus.start), 32'(b == 0));
      chk("beat_valid", 32'(bus.out_valid), 32'd1);
      chk("frame_done", 32'(bus.frame_done), 32'(frame_end && k == 2*IMG_W - 1));
      chk("ready_in_emit", 32'(bus.pix_ready), 32'(k == 2*IMG_W - 1));
      last    = exp;
      obs_max = (b == 0 || bus.data_out > obs_max) ? bus.data_out : obs_max;
      if (b == 3) begin
        mdl_max = rows[2*w];
        if (rows[2*w+1] > mdl_max)       mdl_max = rows[2*w+1];
        if (rows[IMG_W+2*w] > mdl_max)   mdl_max = rows[IMG_W+2*w];
        if (rows[IMG_W+2*w+1] > mdl_max) mdl_max = rows[IMG_W+2*w+1];
        chk("pool_max", 32'(obs_max), 32'(mdl_max));
      end
      if (k == abort_at) begin
        rst = 1'b1;
        tick();
        chk("abort_start", 32'(bus.start), 32'd0);
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_data", 32'(bus.data_out), 32'd0);
        chk("abort_ready", 32'(bus.pix_ready), 32'd0);
        chk("abort_frame", 32'(bus.frame_done), 32'd0);
        rst      = 1'b0;
        pair_idx = 0;
        return;
      end
    end
    pair_idx++;
    tick();
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_start", 32'(bus.start), 32'd0);
    chk("post_frame", 32'(bus.frame_done), 32'd0);
    chk("post_hold", 32'(bus.data_out), 32'(last));
    chk("post_ready", 32'(bus.pix_ready), 32'd1);
  endtask

  task automatic rand_rows(input bit extremes);
    for (int i = 0; i < 2*IMG_W; i++)
      rows[i] = extremes ? ($urandom_range(0, 1) ? px_t'(255) : px_t'(0)) : px_t'($urandom);
  endtask

  initial begin
    px_t held;
    rst           = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(bus.pix_ready), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_start", 32'(bus.start), 32'd0);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_frame", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.pix_ready), 32'd1);

    // rows [1,2,3,4],[5,6,7,8]
    for (int i = 0; i < 2*IMG_W; i++) rows[i] = px_t'(i + 1);
    send_pair(0, 0);
    emit_check(-1);

    // pixel held valid through the replay must land in line0[0] afterwards
    rand_rows(1'b0);
    send_pair(0, -1);
    held          = px_t'($urandom);
    bus.pix_in    = held;
    bus.pix_valid = 1'b1;
    emit_check(-1);
    rand_rows(1'b0);
    rows[0] = held;
    send_pair(1, 2);
    emit_check(-1);

    // pixel every 3rd cycle, 0/255 extremes
    rand_rows(1'b1);
    rows[1] = px_t'(255);
    send_pair(0, 2);
    emit_check(-1);

    // reset after beat 2 of window 0
    rand_rows(1'b0);
    send_pair(0, -1);
    emit_check(2);
    for (int i = 0; i < 2*IMG_W; i++) rows[i] = (i < IMG_W) ? px_t'(9) : px_t'(1);
    send_pair(0, 0);
    emit_check(-1);

    for (int n = 0; n < 5; n++) begin
      rand_rows(n == 2);
      send_pair(0, -1);
      emit_check(-1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
